ntt_control_forward: RTL

//  Sequencer for the forward NTT (Cooley-Tukey, decimation-in-time).

---
 rtl/ntt_pkg.sv | 16 +
 rtl/ntt_addr_gen.sv | 36 +++
 rtl/ntt_control_forward.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the forward and inverse NTT controllers.
// Ports: none (package only).
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } ntt_ctrl_state_t;

    localparam int         CYCLES_PER_BF = 4;
    localparam logic [1:0] CYC_READ      = 2'd0;
    localparam logic [1:0] CYC_VALID     = 2'd2;
    localparam logic [1:0] CYC_WRITE     = 2'd3;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational stage/butterfly -> RAM pair address and twiddle index.
// Ports: stage_i, bf_i in; addr0_o, addr1_o, tw_o out (all ADDR_WIDTH).
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LOGN  = 8,
    parameter int AW    = 8,
    parameter int SW    = 3
) (
    input  logic [SW-1:0] stage_i,
    input  logic [AW-2:0] bf_i,
    output logic [AW-1:0] addr0_o,
    output logic [AW-1:0] addr1_o,
    output logic [AW-1:0] tw_o
);

    logic [AW-1:0] bf_ext;
    logic [AW-1:0] half;
    logic [AW-1:0] group;
    logic [AW-1:0] pos;
    logic [SW-1:0] tw_shift;

    always_comb begin
        bf_ext   = {1'b0, bf_i};
        half     = AW'(1) << stage_i;
        group    = bf_ext >> stage_i;
        pos      = bf_ext & (half - AW'(1));
        // group * (2*half) as a shift by stage+1
        addr0_o  = ((group << stage_i) << 1) + pos;
        addr1_o  = addr0_o + half;
        // Bit-reversed psi table: each stage's block starts at 2^k - 1
        tw_shift = SW'(LOGN - 1) - stage_i;
        tw_o     = (AW'(1) << tw_shift) - AW'(1) + group;
    end

endmodule

// File: rtl/ntt_control_forward.sv
// Forward (Cooley-Tukey) NTT sequencer: stage/butterfly/cycle counters,
// RAM/ROM addressing and butterfly strobes.
// Ports: clk_i, rst_i, start_i, hold_i in; busy_o, done_o, ram_* out,
//        twiddle_addr_o, butterfly_valid_o out.
module ntt_control_forward
    import ntt_pkg::*;
#(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
    output logic                  ram_re_o,
    output logic                  ram_we_a_o,
    output logic                  ram_we_b_o,
    output logic [ADDR_WIDTH-1:0] twiddle_addr_o,
    output logic                  butterfly_valid_o
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = $clog2(LOGN);
    localparam int BW   = ADDR_WIDTH - 1;

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);
    localparam logic [BW-1:0] BF_LAST    = '1;

    ntt_ctrl_state_t state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [BW-1:0]   bf_q, bf_d;
    logic [1:0]      cyc_q, cyc_d;
    logic            busy_q, done_q;
    logic            computing;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bf_d    = bf_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COMPUTE;
                    stage_d = LAST_STAGE;
                    bf_d    = '0;
                    cyc_d   = '0;
                end
            end
            COMPUTE: begin
                if (!hold_i) begin
                    cyc_d = cyc_q + 2'd1;
                    if (cyc_q == CYC_WRITE) begin
                        if (bf_q == BF_LAST) begin
                            bf_d = '0;
                            // Stage saturates at 0; final write ends the run
                            if (stage_q != '0) begin
                                stage_d = stage_q - SW'(1);
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            bf_d = bf_q + BW'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (!start_i) begin
                    state_d = IDLE;
                    stage_d = LAST_STAGE;
                    bf_d    = '0;
                    cyc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            stage_q <= LAST_STAGE;
            bf_q    <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bf_q    <= bf_d;
            cyc_q   <= cyc_d;
            busy_q  <= (state_d == COMPUTE);
            done_q  <= (state_d == DONE);
        end
    end

    ntt_addr_gen #(
        .LOGN (LOGN),
        .AW   (ADDR_WIDTH),
        .SW   (SW)
    ) u_addr_gen (
        .stage_i (stage_q),
        .bf_i    (bf_q),
        .addr0_o (ram_addr_a_o),
        .addr1_o (ram_addr_b_o),
        .tw_o    (twiddle_addr_o)
    );

    assign computing = (state_q == COMPUTE);

    // hold masks strobes combinationally so a frozen cycle never fires twice
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign ram_re_o          = computing;
    assign butterfly_valid_o = computing && (cyc_q == CYC_VALID) && !hold_i;
    assign ram_we_a_o        = computing && (cyc_q == CYC_WRITE) && !hold_i;
    assign ram_we_b_o        = computing && (cyc_q == CYC_WRITE) && !hold_i;

endmodule
